// File: rtl/mips_mem_pkg.sv
// Shared definitions for the data memory responder: bus widths, default
// depth, wait-counter width and the responder state encoding.
package mips_mem_pkg;

    localparam int ADDR_W        = 7;
    localparam int DATA_W        = 32;
    localparam int DEPTH_DEFAULT = 128;
    localparam int CNT_W         = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/mem_wait_counter.sv
// Down-counter that times the BUSY phase of a memory request. It is loaded
// with the wait length on acceptance, counts down once per enabled cycle and
// flags the cycle whose following edge should enter the response phase.
module mem_wait_counter
    import mips_mem_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_value,
    input  logic             dec,
    output logic             last
);

    logic [CNT_W-1:0] count_reg;

    // Load has priority; decrement saturates at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_value;
        end else if (dec && (count_reg != '0)) begin
            count_reg <= count_reg - CNT_W'(1);
        end
    end

    assign last = (count_reg == CNT_W'(1));

endmodule

// File: rtl/data_mem_responder.sv
// Single-outstanding-request data memory. A request is captured in IDLE,
// optionally waits WAIT_CYCLES in BUSY, performs the memory access on the
// edge that enters RESP, and holds the response until the initiator takes it.
// rsp_valid rises one edge after RESP is entered so that the response
// appears WAIT_CYCLES+1 edges after acceptance.
module data_mem_responder
    import mips_mem_pkg::*;
#(
    parameter int WAIT_CYCLES = 2,
    parameter int DEPTH       = DEPTH_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata
);

    localparam int               IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_CYCLES);
    localparam bit               ZERO_WAIT = (WAIT_CYCLES == 0);

    state_t            state_reg;
    state_t            state_next;
    logic              wr_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [DATA_W-1:0] wdata_reg;
    logic [DATA_W-1:0] rdata_reg;
    logic              rsp_valid_reg;
    logic [DATA_W-1:0] mem_reg [DEPTH];

    logic              accept;
    logic              enter_resp;
    logic              rsp_done;
    logic              wait_last;
    logic              acc_write;
    logic [ADDR_W-1:0] acc_addr;
    logic [DATA_W-1:0] acc_wdata;
    logic [IDX_W-1:0]  acc_idx;

    assign accept   = req_valid && (state_reg == IDLE);
    assign rsp_done = rsp_valid_reg && rsp_ready;

    mem_wait_counter u_wait_counter (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (accept && !ZERO_WAIT),
        .load_value (WAIT_LOAD),
        .dec        (state_reg == BUSY),
        .last       (wait_last)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; also marks the edge on which the memory is accessed.
    always_comb begin
        state_next = state_reg;
        enter_resp = 1'b0;
        case (state_reg)
            IDLE: begin
                if (req_valid) begin
                    if (ZERO_WAIT) begin
                        state_next = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_next = BUSY;
                    end
                end
            end
            BUSY: begin
                if (wait_last) begin
                    state_next = RESP;
                    enter_resp = 1'b1;
                end
            end
            RESP: begin
                if (rsp_done) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Access operands: a zero-wait access happens on the acceptance edge
    // itself, before the capture registers are loaded, so use live inputs.
    always_comb begin
        if (state_reg == IDLE) begin
            acc_write = req_write;
            acc_addr  = req_addr;
            acc_wdata = req_wdata;
        end else begin
            acc_write = wr_reg;
            acc_addr  = addr_reg;
            acc_wdata = wdata_reg;
        end
        acc_idx = IDX_W'(32'(acc_addr) % DEPTH);
    end

    // Request capture on acceptance; later input activity cannot disturb it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_reg    <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= '0;
        end else if (accept) begin
            wr_reg    <= req_write;
            addr_reg  <= req_addr;
            wdata_reg <= req_wdata;
        end
    end

    // Memory array and registered read data, updated only when entering RESP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
            rdata_reg <= '0;
        end else if (enter_resp) begin
            if (acc_write) begin
                mem_reg[acc_idx] <= acc_wdata;
                rdata_reg        <= '0;
            end else begin
                rdata_reg <= mem_reg[acc_idx];
            end
        end
    end

    // Response valid: raised one edge into RESP, dropped by the handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_reg <= 1'b0;
        end else if ((state_reg == RESP) && !rsp_valid_reg) begin
            rsp_valid_reg <= 1'b1;
        end else if (rsp_done) begin
            rsp_valid_reg <= 1'b0;
        end
    end

    // Output decode.
    always_comb begin
        req_ready = (state_reg == IDLE);
        rsp_valid = rsp_valid_reg;
        rsp_rdata = rdata_reg;
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: one instance with the default
// two wait cycles and one with zero wait cycles, checked against a reference
// memory model through a queue of expected response data.
module tb_data_mem_responder;

    localparam int W = 2;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        req_valid, req_ready, req_write, rsp_valid, rsp_ready;
    logic [6:0]  req_addr;
    logic [31:0] req_wdata, rsp_rdata;

    logic        z_req_valid, z_req_ready, z_req_write, z_rsp_valid, z_rsp_ready;
    logic [6:0]  z_req_addr;
    logic [31:0] z_req_wdata, z_rsp_rdata;

    int          pass_cnt  = 0;
    int          total_cnt = 0;
    logic [31:0] model_mem [128];
    logic [31:0] exp_q [$];

    always #5 clk = ~clk;

    data_mem_responder #(.WAIT_CYCLES(W), .DEPTH(128)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata)
    );

    data_mem_responder #(.WAIT_CYCLES(0), .DEPTH(128)) dut0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (z_req_valid),
        .req_ready (z_req_ready),
        .req_write (z_req_write),
        .req_addr  (z_req_addr),
        .req_wdata (z_req_wdata),
        .rsp_valid (z_rsp_valid),
        .rsp_ready (z_rsp_ready),
        .rsp_rdata (z_rsp_rdata)
    );

    task automatic clear_model();
        for (int i = 0; i < 128; i++) model_mem[i] = 32'h0;
        exp_q.delete();
    endtask

    // Full reset; returns 1 time unit after a rising edge.
    task automatic apply_reset();
        rst_n = 1'b0;
        req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0; rsp_ready = 0;
        z_req_valid = 0; z_req_write = 0; z_req_addr = 0; z_req_wdata = 0; z_rsp_ready = 0;
        clear_model();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    // One transaction on the WAIT=2 instance with optional back-pressure.
    task automatic run_txn(input string tag, input logic wr, input logic [6:0] addr,
                           input logic [31:0] wdata, input int hold);
        logic [31:0] expv;
        int lat;
        total_cnt++;
        if (req_ready !== 1'b1) $display("FAIL %s_ready: req_ready=%b expected 1", tag, req_ready);
        else pass_cnt++;
        req_valid = 1; req_write = wr; req_addr = addr; req_wdata = wdata;
        @(posedge clk); #1;
        req_valid = 0; req_write = 1'($urandom); req_addr = 7'($urandom); req_wdata = $urandom;
        if (wr) begin
            exp_q.push_back(32'h0);
            model_mem[addr] = wdata;
        end else begin
            exp_q.push_back(model_mem[addr]);
        end
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (rsp_valid === 1'b1) begin lat = k; break; end
        end
        expv = exp_q.pop_front();
        total_cnt++;
        if (lat != W + 1) begin
            $display("FAIL %s_latency: got %0d edges, expected %0d", tag, lat, W + 1);
            return;
        end
        pass_cnt++;
        total_cnt++;
        if (rsp_rdata !== expv || req_ready !== 1'b0)
            $display("FAIL %s_data: rdata=%h req_ready=%b expected rdata=%h req_ready=0", tag, rsp_rdata, req_ready, expv);
        else pass_cnt++;
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            total_cnt++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== expv || req_ready !== 1'b0)
                $display("FAIL %s_hold%0d: valid=%b rdata=%h req_ready=%b expected 1/%h/0", tag, k, rsp_valid, rsp_rdata, req_ready, expv);
            else pass_cnt++;
        end
        rsp_ready = 1;
        @(posedge clk); #1;
        rsp_ready = 0;
        total_cnt++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1)
            $display("FAIL %s_release: valid=%b req_ready=%b expected 0/1", tag, rsp_valid, req_ready);
        else pass_cnt++;
        $display("txn %s wr=%0b addr=%0d data=%h", tag, wr, addr, expv);
    endtask

    task automatic test_reset();
        apply_reset();
        total_cnt++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_rdata !== 32'h0)
            $display("FAIL reset_state: ready=%b valid=%b rdata=%h expected 1/0/00000000", req_ready, rsp_valid, rsp_rdata);
        else pass_cnt++;
        total_cnt++;
        if (z_req_ready !== 1'b1 || z_rsp_valid !== 1'b0 || z_rsp_rdata !== 32'h0)
            $display("FAIL reset_state_w0: ready=%b valid=%b rdata=%h expected 1/0/00000000", z_req_ready, z_rsp_valid, z_rsp_rdata);
        else pass_cnt++;
    endtask

    task automatic test_read_after_reset();
        run_txn("rd5_after_reset", 1'b0, 7'd5, 32'h0, 0);
    endtask

    task automatic test_write_read();
        run_txn("wr10", 1'b1, 7'd10, 32'hDEADBEEF, 0);
        run_txn("rd10", 1'b0, 7'd10, 32'h0, 0);
    endtask

    task automatic test_backpressure();
        run_txn("rd10_hold5", 1'b0, 7'd10, 32'h0, 5);
    endtask

    // rsp_ready held high before rsp_valid rises must not end the response early.
    task automatic test_ready_early();
        logic [31:0] expv;
        int lat = 0;
        rsp_ready = 1;
        req_valid = 1; req_write = 0; req_addr = 7'd10; req_wdata = 0;
        @(posedge clk); #1;
        req_valid = 0;
        exp_q.push_back(model_mem[10]);
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (rsp_valid === 1'b1) begin lat = k; break; end
        end
        expv = exp_q.pop_front();
        total_cnt++;
        if (lat != W + 1 || rsp_rdata !== expv)
            $display("FAIL ready_early_rsp: lat=%0d rdata=%h expected lat=%0d rdata=%h", lat, rsp_rdata, W + 1, expv);
        else pass_cnt++;
        @(posedge clk); #1;
        rsp_ready = 0;
        total_cnt++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1)
            $display("FAIL ready_early_release: valid=%b ready=%b expected 0/1", rsp_valid, req_ready);
        else pass_cnt++;
        $display("txn ready_early addr=10 data=%h", expv);
    endtask

    // Input noise while BUSY must not alter the captured request.
    task automatic test_busy_noise();
        logic [31:0] expv;
        int lat = 0;
        req_valid = 1; req_write = 0; req_addr = 7'd10; req_wdata = 0;
        @(posedge clk); #1;
        exp_q.push_back(model_mem[10]);
        total_cnt++;
        if (req_ready !== 1'b0) $display("FAIL noise_busy_ready: req_ready=%b expected 0", req_ready);
        else pass_cnt++;
        for (int k = 1; k <= 40; k++) begin
            req_valid = (k % 2 == 1); req_write = 1; req_addr = 7'd20; req_wdata = 32'h1111_1111;
            @(posedge clk); #1;
            if (rsp_valid === 1'b1) begin lat = k; break; end
        end
        req_valid = 0; req_write = 0;
        expv = exp_q.pop_front();
        total_cnt++;
        if (lat != W + 1 || rsp_rdata !== expv)
            $display("FAIL noise_rsp: lat=%0d rdata=%h expected lat=%0d rdata=%h", lat, rsp_rdata, W + 1, expv);
        else pass_cnt++;
        rsp_ready = 1;
        @(posedge clk); #1;
        rsp_ready = 0;
        $display("txn busy_noise addr=10 data=%h", expv);
        run_txn("noise_rd20", 1'b0, 7'd20, 32'h0, 0);
    endtask

    task automatic test_back_to_back();
        logic [6:0] addrs [4];
        addrs[0] = 7'd0; addrs[1] = 7'd127; addrs[2] = 7'd64; addrs[3] = 7'd10;
        for (int i = 0; i < 4; i++)
            run_txn("b2b_wr", 1'b1, addrs[i], $urandom, i % 3);
        for (int i = 3; i >= 0; i--)
            run_txn("b2b_rd", 1'b0, addrs[i], 32'h0, i % 2);
    endtask

    // WAIT_CYCLES=0 instance: response one edge after acceptance.
    task automatic test_zero_wait();
        logic [31:0] expv;
        int lat;
        for (int t = 0; t < 2; t++) begin
            total_cnt++;
            if (z_req_ready !== 1'b1) $display("FAIL w0_ready%0d: req_ready=%b expected 1", t, z_req_ready);
            else pass_cnt++;
            z_req_valid = 1; z_req_write = (t == 0); z_req_addr = 7'd127; z_req_wdata = 32'h12345678;
            @(posedge clk); #1;
            z_req_valid = 0; z_req_addr = 7'd1; z_req_wdata = 32'hFFFF_FFFF;
            exp_q.push_back((t == 0) ? 32'h0 : 32'h12345678);
            lat = 0;
            for (int k = 1; k <= 40; k++) begin
                @(posedge clk); #1;
                if (z_rsp_valid === 1'b1) begin lat = k; break; end
            end
            expv = exp_q.pop_front();
            total_cnt++;
            if (lat != 1 || z_rsp_rdata !== expv)
                $display("FAIL w0_rsp%0d: lat=%0d rdata=%h expected lat=1 rdata=%h", t, lat, z_rsp_rdata, expv);
            else pass_cnt++;
            z_rsp_ready = 1;
            @(posedge clk); #1;
            z_rsp_ready = 0;
            total_cnt++;
            if (z_rsp_valid !== 1'b0 || z_req_ready !== 1'b1)
                $display("FAIL w0_release%0d: valid=%b ready=%b expected 0/1", t, z_rsp_valid, z_req_ready);
            else pass_cnt++;
            $display("txn w0 wr=%0d addr=127 data=%h", (t == 0), expv);
        end
    endtask

    task automatic test_reset_busy();
        req_valid = 1; req_write = 1; req_addr = 7'd3; req_wdata = 32'hA5A5A5A5;
        @(posedge clk); #1;
        req_valid = 0; req_write = 0;
        @(posedge clk); #1;
        rst_n = 0;
        #1;
        total_cnt++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || rsp_rdata !== 32'h0)
            $display("FAIL reset_busy_state: valid=%b ready=%b rdata=%h expected 0/1/00000000", rsp_valid, req_ready, rsp_rdata);
        else pass_cnt++;
        clear_model();
        #2 rst_n = 1;
        @(posedge clk); #1;
        run_txn("rd3_after_busy_reset", 1'b0, 7'd3, 32'h0, 0);
    endtask

    task automatic test_reset_resp();
        int seen = 0;
        run_txn("wr40", 1'b1, 7'd40, 32'hCAFE_F00D, 0);
        req_valid = 1; req_write = 0; req_addr = 7'd40;
        @(posedge clk); #1;
        req_valid = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (rsp_valid === 1'b1) break;
        end
        rst_n = 0;
        #1;
        total_cnt++;
        if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h0)
            $display("FAIL reset_resp_state: valid=%b rdata=%h expected 0/00000000", rsp_valid, rsp_rdata);
        else pass_cnt++;
        clear_model();
        #2 rst_n = 1;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            if (rsp_valid !== 1'b0) seen++;
        end
        total_cnt++;
        if (seen != 0) $display("FAIL reset_resp_replay: rsp_valid high %0d cycles, expected 0", seen);
        else pass_cnt++;
        run_txn("rd40_after_resp_reset", 1'b0, 7'd40, 32'h0, 0);
    endtask

    initial begin
        test_reset();
        test_read_after_reset();
        test_write_read();
        test_backpressure();
        test_ready_early();
        test_busy_noise();
        test_back_to_back();
        test_zero_wait();
        test_reset_busy();
        test_reset_resp();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
